// File: rtl/spi_slave_rx.sv
// SPI receive endpoint: oversamples sclk/cs/mosi into clk and
// deserializes LSB-first frames, strobing done per full word.
module spi_slave_rx #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WAIT_CS
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_d_q;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   fall;

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign fall   = sclk_d_q & ~sclk_s;

  // cs chain resets high so a reset never looks like a frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_d_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_d_q    <= sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!cs_s) state_d = RECV;
      end
      RECV: begin
        // cs release wins over a coincident sclk fall
        if (cs_s) begin
          ferr_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else if (fall) begin
          shreg_d = {mosi_s, shreg_q[DATA_W-1:1]};
          if (bit_cnt_q == CW'(DATA_W - 1)) begin
            dout_d    = shreg_d;
            done_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = WAIT_CS;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      WAIT_CS: begin
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout      = dout_q;
  assign done      = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: table-driven and random SPI frames
// compared against a frame-level expectation model.
module tb_spi_slave_rx;

  localparam int PH = 51;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic [11:0] dout;
  logic        done;
  logic        frame_err;
  logic        busy;

  spi_slave_rx #(.DATA_W(12), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout), .done(done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_done = 0;
  int n_ferr = 0;
  int done_cyc = 0;
  int fall_cyc = 0;
  logic both_seen = 1'b0;
  logic [11:0] exp_dout = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (done && frame_err) both_seen <= 1'b1;
  end

  typedef struct {
    logic [11:0] d;
    int          nf;
    int          extra;
    int          gap;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [11:0] d, input int nf,
                      input int extra, input bit raise);
    wclk(1);
    cs = 1'b0;
    wclk(PH);
    for (int i = 0; i < nf + extra; i++) begin
      mosi = (i < 12) ? d[i] : 1'($urandom);
      sclk = 1'b1;
      wclk(PH);
      sclk = 1'b0;
      if (i == 11) fall_cyc = cyc;
      wclk(PH);
    end
    if (raise) cs = 1'b1;
  endtask

  task automatic frame(input string name, input logic [11:0] d,
                       input int nf, input int extra, input int gap);
    int d0;
    int f0;
    d0 = n_done;
    f0 = n_ferr;
    send(d, nf, extra, 1'b1);
    wclk(gap);
    if (nf >= 12) begin
      exp_dout = d;
      chk({name, " done count"}, n_done - d0, 1);
      chk({name, " ferr count"}, n_ferr - f0, 0);
      chk({name, " done latency"}, done_cyc - fall_cyc, 3);
    end else begin
      chk({name, " done count"}, n_done - d0, 0);
      chk({name, " ferr count"}, n_ferr - f0, 1);
    end
    chk({name, " dout"}, int'(dout), int'(exp_dout));
    chk({name, " busy"}, int'(busy), 0);
    chk({name, " done&ferr"}, int'(both_seen), 0);
  endtask

  initial begin
    int d0;
    int f0;
    int nf;
    int ex;

    tbl[0] = '{12'hA5C, 12, 0, 6};
    tbl[1] = '{12'hFFF, 12, 0, 4};
    tbl[2] = '{12'h000, 12, 0, 4};
    tbl[3] = '{12'h801, 12, 0, 4};
    tbl[4] = '{12'h3C7, 5, 0, 6};
    tbl[5] = '{12'h123, 12, 0, 6};
    tbl[6] = '{12'h5A5, 12, 3, 6};

    // reset held while the pins toggle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sclk = ~sclk;
      cs   = ~cs;
      mosi = ~mosi;
      chk("reset outputs", int'({dout, done, frame_err, busy}), 0);
    end
    @(negedge clk);
    sclk = 1'b0;
    cs   = 1'b1;
    mosi = 1'b0;
    wclk(1);
    rst = 1'b0;
    wclk(5);
    chk("post-reset outputs", int'({dout, done, frame_err, busy}), 0);

    for (int i = 0; i < 7; i++)
      frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].nf,
            tbl[i].extra, tbl[i].gap);

    // reset in the middle of a frame
    d0 = n_done;
    f0 = n_ferr;
    send(12'hABC, 7, 0, 1'b0);
    rst  = 1'b1;
    cs   = 1'b1;
    sclk = 1'b0;
    wclk(3);
    rst = 1'b0;
    wclk(6);
    exp_dout = '0;
    chk("midrst done count", n_done - d0, 0);
    chk("midrst ferr count", n_ferr - f0, 0);
    chk("midrst dout", int'(dout), 0);
    chk("midrst busy", int'(busy), 0);
    frame("after-rst", 12'h0F0, 12, 0, 6);

    for (int i = 0; i < 6; i++) begin
      nf = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : 12;
      ex = (nf == 12) ? int'($urandom_range(0, 2)) : 0;
      frame($sformatf("rand%0d", i), 12'($urandom), nf, ex,
            int'($urandom_range(4, 10)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
